// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared Gray/binary helpers and constants for the async FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int GRAY_MAX_W  = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

  function automatic gray_vec_t width_mask(input int width);
    gray_vec_t m;
    if (width >= GRAY_MAX_W) m = '1;
    else                     m = (gray_vec_t'(1) << width) - gray_vec_t'(1);
    return m;
  endfunction

  function automatic gray_vec_t bin2gray(input gray_vec_t b, input int width);
    gray_vec_t v;
    v = b & width_mask(width);
    return v ^ (v >> 1);
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic gray_vec_t gray2bin(input gray_vec_t g, input int width);
    gray_vec_t v;
    gray_vec_t b;
    v = g & width_mask(width);
    b = v;
    for (int i = 1; i < GRAY_MAX_W; i++) begin
      b = b ^ (v >> i);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : W-bit flop-chain synchroniser, synchronous active-high reset.
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_stage [SYNC_STAGES];

  // Plain flop-to-flop chain: nothing may sit between the stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/readcontrol_sync.sv
`default_nettype none
// ============================================================================
//  Module   : readcontrol_sync
//  Purpose  : Async FIFO read-side pointers, RAM read strobe and status flags.
//  Revision : 1.0  initial release
// ============================================================================
module readcontrol_sync
  import fifo_pkg::*;
#(
  parameter int ptr_width = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_en,
  input  logic [ptr_width:0]   g_wptr_async,
  output logic                 r_fire,
  output logic [ptr_width-1:0] r_addr,
  output logic [ptr_width:0]   b_rptr,
  output logic [ptr_width:0]   g_rptr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [ptr_width:0]   level,
  output logic                 underflow
);

  localparam int          c_PW     = ptr_width + 1;
  localparam logic [31:0] c_AE_LIM = 32'(AE_THRESH);

  logic [ptr_width:0] w_g_wptr_sync;
  logic [ptr_width:0] w_b_wptr_sync;
  logic [ptr_width:0] w_b_rptr_next;
  logic [ptr_width:0] w_g_rptr_next;
  logic [ptr_width:0] w_level_next;
  logic               w_empty_next;
  logic               w_ae_next;

  sync_2ff #(
    .W (c_PW)
  ) u_wptr_sync (
    .clk (r_clk),
    .rst (r_rst),
    .d   (g_wptr_async),
    .q   (w_g_wptr_sync)
  );

  assign r_fire = r_en & ~empty;
  assign r_addr = b_rptr[ptr_width-1:0];

  assign w_b_rptr_next = b_rptr + {{ptr_width{1'b0}}, r_fire};
  assign w_g_rptr_next = c_PW'(bin2gray(gray_vec_t'(w_b_rptr_next), c_PW));
  assign w_b_wptr_sync = c_PW'(gray2bin(gray_vec_t'(w_g_wptr_sync), c_PW));

  // Flags are computed from the post-read pointer so the last-word read
  // raises empty on the very edge that accepts it.
  assign w_level_next = w_b_wptr_sync - w_b_rptr_next;
  assign w_empty_next = (w_g_rptr_next == w_g_wptr_sync);
  assign w_ae_next    = (32'(w_level_next) <= c_AE_LIM);

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      level        <= '0;
      underflow    <= 1'b0;
    end else begin
      b_rptr       <= w_b_rptr_next;
      g_rptr       <= w_g_rptr_next;
      empty        <= w_empty_next;
      almost_empty <= w_ae_next;
      level        <= w_level_next;
      underflow    <= underflow | (r_en & empty);
    end
  end

endmodule
`default_nettype wire
